mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand width and width of HI and LO.
REQ-002 Parameter MULT_CYCLES, default 5: latency of multiply-class ops, legal range 1..63.
REQ-003 Parameter DIV_CYCLES, default 10: latency of divide-class ops, legal range 1..63.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  op/a/b valid this cycle.
REQ-007 op  input  4  operation code (package encoding).
REQ-008 a  input  WIDTH  operand 1 (rs).
REQ-009 b  input  WIDTH  operand 2 (rt).
REQ-010 cancel  input  1  abort in-flight op (exception flush).
REQ-011 busy  output  1  op in flight; the core stalls md instructions on start|busy.
REQ-012 hi  output  WIDTH  architectural HI register.
REQ-013 lo  output  WIDTH  architectural LO register.

Function
REQ-014 Ops: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; any other code is a NOP.
REQ-015 State machine has two states, IDLE and BUSY; busy is 1 exactly in BUSY.
REQ-016 In IDLE, start with a multiply-class op latches the result into pending registers, loads the counter with MULT_CYCLES and enters BUSY.
REQ-017 In IDLE, start with DIV/DIVU does the same with DIV_CYCLES.
REQ-018 The counter decrements every BUSY cycle; the edge on which it reaches 0 writes pending to hi/lo and returns to IDLE.
REQ-019 busy is high for exactly the op's latency in cycles; new hi/lo are visible in the first cycle busy is 0.
REQ-020 MTHI/MTLO in IDLE write a to hi/lo at the accepting edge; busy is not asserted.
REQ-021 start in BUSY is ignored, and state and pending registers are unchanged.
REQ-022 MULT and MADD/MSUB are signed; MULTU, MADDU and MSUBU are unsigned; the product is 2*WIDTH bits, with {hi,lo} = product.
REQ-023 MADD/MADDU set {hi,lo} to {hi,lo} + product; MSUB/MSUBU set {hi,lo} to {hi,lo} - product; the accumulator is sampled at acceptance and wraps modulo 2^(2*WIDTH).
REQ-024 DIV/DIVU set lo to the quotient (truncated toward zero) and hi to the remainder (sign of a).
REQ-025 If b == 0, lo is all ones and hi = a, for both signed and unsigned division.
REQ-026 For signed MIN / -1, lo = MIN and hi = 0.
REQ-027 cancel in BUSY returns to IDLE on the next edge; hi/lo are not written and pending results are discarded.
REQ-028 cancel together with start in IDLE causes the start to be ignored.
REQ-029 cancel on the completing edge takes precedence, so hi/lo are not written.

Reset
REQ-030 When reset is sampled high, the block enters IDLE, and the counter, pending, hi, lo and busy all become 0.
REQ-031 Reset takes precedence over cancel, start and completion, including mid-operation.

Configuration
REQ-032 Macro MDU_MADD_EN defined: ops 7..10 behave per REQ-023.
REQ-033 Macro MDU_MADD_EN undefined: ops 7..10 are NOPs, busy stays 0, hi/lo are unchanged, and no accumulator adder is synthesised.

Structure
REQ-034 Package mdu_pkg holds the op-code constants, the default latency constants and the state encoding.
REQ-035 Sub-module mdu_core holds the purely combinational product, accumulate and quotient/remainder computation, parametrised by WIDTH; mdu holds the FSM, counter and registers.

Verification
REQ-036 Bench checks MULT a=0xFFFFFFFF b=2: busy is high for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFE; MULTU on the same operands gives hi=1 and lo=0xFFFFFFFE.
REQ-037 Bench checks DIV a=-7 b=2: busy for 10 cycles, then lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1); DIVU 7/0 gives lo=0xFFFFFFFF and hi=7.
REQ-038 Bench checks DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000 and hi=0.
REQ-039 Bench checks MTHI 0x1234 while IDLE: hi=0x1234 on the next cycle with busy=0; MTLO issued during a MULT is ignored.
REQ-040 Bench checks a DIV with cancel asserted in its 4th busy cycle: busy=0 on the next cycle and hi/lo hold their prior values; reset in the 3rd busy cycle gives all outputs 0 on the next cycle.
REQ-041 Bench checks, with MDU_MADD_EN defined, hi=0 lo=0xFFFFFFFF followed by MADDU 1*1: hi=1 and lo=0; without the macro the same op leaves hi/lo unchanged and busy=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default
// latencies, FSM state encoding and op-class helpers.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Ops that run with the multiply latency (accumulating ops only when built in).
    function automatic logic is_mult_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational datapath of the MDU: signed/unsigned product, optional
// HI/LO accumulate, and quotient/remainder with the divide-by-zero and
// MIN/-1 corner cases. Optional macro: MDU_MADD_EN.
import mdu_pkg::*;

module mdu_core #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic               mul_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic               div_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
`ifdef MDU_MADD_EN
    logic [2*WIDTH-1:0] acc;
`endif

    // Product: extend operands to 2*WIDTH so the low 2*WIDTH bits are exact
    // for both signed and unsigned interpretation.
    always_comb begin
        mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
        a_ext      = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext      = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod       = a_ext * b_ext;
    end

    // One unsigned divider on magnitudes; signs are re-applied afterwards.
    // MIN/-1 falls out naturally: |MIN| / 1 negated twice wraps back to MIN.
    always_comb begin
        div_signed = (op == OP_DIV);
        a_neg      = div_signed && a[WIDTH-1];
        b_neg      = div_signed && b[WIDTH-1];
        a_mag      = a_neg ? (~a + 1'b1) : a;
        b_mag      = b_neg ? (~b + 1'b1) : b;
        uq         = '0;
        ur         = '0;
        if (b != '0) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
        rem  = a_neg ? (~ur + 1'b1) : ur;
        if (b == '0) begin
            quot = '1;
            rem  = a;
        end
    end

`ifdef MDU_MADD_EN
    // Accumulate against the HI/LO value seen at acceptance, wrapping.
    always_comb begin
        if ((op == OP_MSUB) || (op == OP_MSUBU))
            acc = {hi, lo} - prod;
        else
            acc = {hi, lo} + prod;
    end
`endif

    // Select the result pair by op class; anything else keeps HI/LO.
    always_comb begin
        {res_hi, res_lo} = {hi, lo};
        case (op)
            OP_MULT, OP_MULTU: {res_hi, res_lo} = prod;
            OP_DIV, OP_DIVU:   {res_hi, res_lo} = {rem, quot};
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: {res_hi, res_lo} = acc;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit top: IDLE/BUSY FSM, latency counter, pending result
// registers and architectural HI/LO. Optional macro: MDU_MADD_EN.
import mdu_pkg::*;

module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] MULT_CNT = 6'(MULT_CYCLES);
    localparam logic [5:0] DIV_CNT  = 6'(DIV_CYCLES);

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Next-state: accept in IDLE, count down in BUSY, commit on the last edge
    // unless cancel flushes the op.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    if (is_mult_op(op)) begin
                        pend_hi_d = res_hi;
                        pend_lo_d = res_lo;
                        cnt_d     = MULT_CNT;
                        state_d   = ST_BUSY;
                    end else if (is_div_op(op)) begin
                        pend_hi_d = res_hi;
                        pend_lo_d = res_lo;
                        cnt_d     = DIV_CNT;
                        state_d   = ST_BUSY;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_BUSY: begin
                if (cancel) begin
                    cnt_d     = '0;
                    pend_hi_d = '0;
                    pend_lo_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        hi_d    = pend_hi_q;
                        lo_d    = pend_lo_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: the driver queues hand-computed results, and a
// monitor pops and compares whenever an op completes (busy falls) or an
// immediate op is flagged. Build with or without MDU_MADD_EN.
import mdu_pkg::*;

module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    string       q_name[$];
    int          q_lat[$];
    logic [31:0] q_hi[$];
    logic [31:0] q_lo[$];

    logic chk_req = 1'b0;
    logic prev_busy = 1'b0;
    int   bcnt = 0;

    mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Monitor: count busy cycles, compare on completion or immediate-op flag.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            bcnt = bcnt + 1;
        end else if (prev_busy === 1'b1 || chk_req === 1'b1) begin
            if (q_name.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_completion: hi=%h lo=%h busy_cycles=%0d, no result expected", hi, lo, bcnt);
            end else begin
                string       nm;
                int          el;
                logic [31:0] eh;
                logic [31:0] elo;
                nm  = q_name.pop_front();
                el  = q_lat.pop_front();
                eh  = q_hi.pop_front();
                elo = q_lo.pop_front();
                checks = checks + 1;
                if (bcnt != el) begin
                    errors = errors + 1;
                    $display("FAIL %s busy_cycles: got %0d, expected %0d", nm, bcnt, el);
                end
                checks = checks + 1;
                if (hi !== eh) begin
                    errors = errors + 1;
                    $display("FAIL %s hi: got %h, expected %h", nm, hi, eh);
                end
                checks = checks + 1;
                if (lo !== elo) begin
                    errors = errors + 1;
                    $display("FAIL %s lo: got %h, expected %h", nm, lo, elo);
                end
                $display("txn %-14s busy_cycles=%0d hi=%h lo=%h", nm, bcnt, hi, lo);
            end
            bcnt = 0;
        end
        prev_busy = busy;
    end

    // Issue one op; cyc = cycles to wait, *_at = busy cycle in which to pulse
    // cancel / reset / a stray MTLO (0 = never).
    task automatic run_op(input logic [3:0] o, input logic [31:0] ai, input logic [31:0] bi,
                          input int cyc, input int cancel_at, input int reset_at,
                          input int mtlo_at, input bit idle_cancel, input int lat,
                          input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        q_name.push_back(nm);
        q_lat.push_back(lat);
        q_hi.push_back(ehi);
        q_lo.push_back(elo);
        start  = 1'b1;
        op     = o;
        a      = ai;
        b      = bi;
        cancel = idle_cancel;
        @(posedge clk); #1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = OP_NOP;
        if (cyc == 0) begin
            chk_req = 1'b1;
            @(posedge clk); #1;
            chk_req = 1'b0;
        end else begin
            for (int c = 1; c <= cyc; c++) begin
                if (c == cancel_at) cancel = 1'b1;
                if (c == reset_at) reset = 1'b1;
                if (c == mtlo_at) begin
                    start = 1'b1;
                    op    = OP_MTLO;
                    a     = 32'h0000_dead;
                end
                @(posedge clk); #1;
                cancel = 1'b0;
                reset  = 1'b0;
                start  = 1'b0;
                op     = OP_NOP;
                if (c == cancel_at || c == reset_at) break;
            end
        end
        @(negedge clk); #1;
    endtask

    // Watchdog so a stuck DUT cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = OP_NOP;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;

        //     op        a             b             cyc can rst mtlo ic lat  hi            lo
        run_op(OP_NOP,   32'h0,        32'h0,        0,  0,  0,  0,   0, 0,  32'h0,        32'h0,        "reset_state");
        run_op(OP_MULT,  32'hffffffff, 32'h2,        5,  0,  0,  0,   0, 5,  32'hffffffff, 32'hfffffffe, "mult_m1x2");
        run_op(OP_MULTU, 32'hffffffff, 32'h2,        5,  0,  0,  0,   0, 5,  32'h00000001, 32'hfffffffe, "multu_max_x2");
        run_op(OP_DIV,   32'hfffffff9, 32'h2,        10, 0,  0,  0,   0, 10, 32'hffffffff, 32'hfffffffd, "div_m7_2");
        run_op(OP_DIVU,  32'h7,        32'h0,        10, 0,  0,  0,   0, 10, 32'h00000007, 32'hffffffff, "divu_7_0");
        run_op(OP_DIV,   32'h80000000, 32'hffffffff, 10, 0,  0,  0,   0, 10, 32'h00000000, 32'h80000000, "div_min_m1");
        run_op(OP_DIV,   32'hfffffffb, 32'h0,        10, 0,  0,  0,   0, 10, 32'hfffffffb, 32'hffffffff, "div_m5_0");
        run_op(OP_MTHI,  32'h1234,     32'h0,        0,  0,  0,  0,   0, 0,  32'h00001234, 32'hffffffff, "mthi_1234");
        run_op(OP_MTLO,  32'h0,        32'h0,        0,  0,  0,  0,   0, 0,  32'h00001234, 32'h00000000, "mtlo_0");
        run_op(4'd15,    32'h55,       32'h66,       0,  0,  0,  0,   0, 0,  32'h00001234, 32'h00000000, "op15_nop");
        run_op(OP_MULT,  32'h3,        32'hfffffffc, 5,  0,  0,  2,   0, 5,  32'hffffffff, 32'hfffffff4, "mult_mtlo_busy");
        run_op(OP_DIVU,  32'd100,      32'd7,        10, 4,  0,  0,   0, 4,  32'hffffffff, 32'hfffffff4, "divu_cancel4");
        run_op(OP_DIVU,  32'd100,      32'd7,        10, 0,  0,  0,   0, 10, 32'h00000002, 32'h0000000e, "divu_100_7");
        run_op(OP_MULT,  32'h5,        32'h5,        0,  0,  0,  0,   1, 0,  32'h00000002, 32'h0000000e, "start_cancel");
        run_op(OP_DIV,   32'd100,      32'd7,        10, 0,  3,  0,   0, 3,  32'h00000000, 32'h00000000, "div_reset3");
        run_op(OP_MTHI,  32'h0,        32'h0,        0,  0,  0,  0,   0, 0,  32'h00000000, 32'h00000000, "mthi_0");
        run_op(OP_MTLO,  32'hffffffff, 32'h0,        0,  0,  0,  0,   0, 0,  32'h00000000, 32'hffffffff, "mtlo_ones");
`ifdef MDU_MADD_EN
        run_op(OP_MADDU, 32'h1,        32'h1,        5,  0,  0,  0,   0, 5,  32'h00000001, 32'h00000000, "maddu_1x1");
        run_op(OP_MSUB,  32'h2,        32'h3,        5,  0,  0,  0,   0, 5,  32'h00000000, 32'hfffffffa, "msub_2x3");
        run_op(OP_MADD,  32'hffffffff, 32'h1,        5,  0,  0,  0,   0, 5,  32'h00000000, 32'hfffffff9, "madd_m1x1");
`else
        run_op(OP_MADDU, 32'h1,        32'h1,        0,  0,  0,  0,   0, 0,  32'h00000000, 32'hffffffff, "maddu_off");
        run_op(OP_MSUB,  32'h2,        32'h3,        0,  0,  0,  0,   0, 0,  32'h00000000, 32'hffffffff, "msub_off");
`endif

        repeat (3) @(posedge clk);
        #1;
        checks = checks + 1;
        if (q_name.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", q_name.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
